// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the data-memory access stage.
// Holds the access FSM encoding and the memory/timeout sizing defaults.
package mem_stage_pkg;

   localparam int DMEM_WORDS_DEF  = 1024;
   localparam int TIMEOUT_CYC_DEF = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait counter for an outstanding data-memory access.
// expired is high on the LIMIT-th enabled cycle after clear.
module mem_timeout_ctr #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: stalls upstream while a word access to data memory
// is outstanding, flags misaligned/out-of-range/timed-out accesses.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int DMEM_WORDS  = DMEM_WORDS_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        MemToReg_in,
   input  logic        RegWrite_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] wdata_in,
   input  logic [3:0]  RR3_in,
   output logic [31:0] mem_out,
   output logic [31:0] alu_out,
   output logic        MemToReg_out,
   output logic        RegWrite_out,
   output logic [3:0]  RR3_out,
   output logic        stall_out,
   output logic        dm_req,
   output logic        dm_we,
   output logic [29:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        mem_fault,
   output logic [7:0]  fault_cnt
);

   mem_state_e  state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] data_q, data_d;
   logic        to_q, to_d;
   logic        fault_q, fault_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        pend;
   logic        fault;
   logic        misal;
   logic        oor;
   logic        expired;
   logic [31:0] word_addr;

   assign word_addr = {2'b00, alu_in[31:2]};
   assign misal     = (alu_in[1:0] != 2'b00);
   assign oor       = (word_addr >= 32'(DMEM_WORDS));
   assign pend      = MemRead_in ^ MemWrite_in;
   assign fault     = (MemRead_in & MemWrite_in) | (pend & (misal | oor));

   mem_timeout_ctr #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q != BUSY),
      .enable  (state_q == BUSY),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      to_d    = to_q;
      fault_d = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (fault) begin
               fault_d = 1'b1;
            end else if (pend) begin
               state_d = BUSY;
               req_d   = 1'b1;
               we_d    = MemWrite_in;
               addr_d  = alu_in[31:2];
               wdata_d = wdata_in;
               to_d    = 1'b0;
            end
         end
         BUSY: begin
            // ack wins over a coincident timeout
            if (dm_ack) begin
               state_d = DONE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               data_d  = we_q ? 32'h0 : dm_rdata;
               to_d    = 1'b0;
            end else if (expired) begin
               state_d = DONE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               data_d  = 32'h0;
               to_d    = 1'b1;
               fault_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (fault_d && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         to_q    <= 1'b0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         to_q    <= to_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   assign alu_out      = alu_in;
   assign MemToReg_out = MemToReg_in;
   assign RR3_out      = RR3_in;
   assign RegWrite_out = RegWrite_in
                       & ~((state_q == IDLE) & fault & MemRead_in)
                       & ~((state_q == DONE) & to_q);
   assign stall_out    = (state_q == BUSY)
                       | ((state_q == IDLE) & pend & ~fault);
   assign mem_out      = (state_q == DONE) ? data_q : 32'h0;
   assign dm_req       = req_q;
   assign dm_we        = we_q;
   assign dm_addr      = addr_q;
   assign dm_wdata     = wdata_q;
   assign mem_fault    = fault_q;
   assign fault_cnt    = cnt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level expectations
// checked every cycle, plus literal pins for the headline scenarios.
module tb_mem_access_stage;

   localparam int DW = 1024;
   localparam int TO = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in;
   logic [31:0] alu_in, wdata_in;
   logic [3:0]  RR3_in;
   logic [31:0] mem_out, alu_out;
   logic        MemToReg_out, RegWrite_out;
   logic [3:0]  RR3_out;
   logic        stall_out, dm_req, dm_we;
   logic [29:0] dm_addr;
   logic [31:0] dm_wdata, dm_rdata;
   logic        dm_ack, mem_fault;
   logic [7:0]  fault_cnt;

   mem_access_stage #(
      .DMEM_WORDS  (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .MemRead_in   (MemRead_in),
      .MemWrite_in  (MemWrite_in),
      .MemToReg_in  (MemToReg_in),
      .RegWrite_in  (RegWrite_in),
      .alu_in       (alu_in),
      .wdata_in     (wdata_in),
      .RR3_in       (RR3_in),
      .mem_out      (mem_out),
      .alu_out      (alu_out),
      .MemToReg_out (MemToReg_out),
      .RegWrite_out (RegWrite_out),
      .RR3_out      (RR3_out),
      .stall_out    (stall_out),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata),
      .dm_ack       (dm_ack),
      .mem_fault    (mem_fault),
      .fault_cnt    (fault_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int stall_seen = 0;

   logic        chk_en = 1'b0;
   logic        exp_stall, exp_req, exp_we, exp_mem_chk, exp_rw, exp_fault;
   logic [31:0] exp_addr, exp_wdata, exp_mem;
   logic [7:0]  exp_cnt;

   int  nf = 0;
   logic fault_pend = 1'b0;

   string       q_name[$];
   logic [31:0] q_act[$];
   logic [31:0] q_exp[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", {31'b0, stall_out}, {31'b0, exp_stall});
         chk("dm_req", {31'b0, dm_req}, {31'b0, exp_req});
         if (exp_req) begin
            chk("dm_we", {31'b0, dm_we}, {31'b0, exp_we});
            chk("dm_addr", {2'b0, dm_addr}, exp_addr);
            chk("dm_wdata", dm_wdata, exp_wdata);
         end
         if (exp_mem_chk) chk("mem_out", mem_out, exp_mem);
         chk("alu_out", alu_out, alu_in);
         chk("m2r", {31'b0, MemToReg_out}, {31'b0, MemToReg_in});
         chk("rr3", {28'b0, RR3_out}, {28'b0, RR3_in});
         chk("regwrite", {31'b0, RegWrite_out}, {31'b0, exp_rw});
         chk("mem_fault", {31'b0, mem_fault}, {31'b0, exp_fault});
         chk("fault_cnt", {24'b0, fault_cnt}, {24'b0, exp_cnt});
         if (stall_out) stall_seen++;
      end
      while (q_name.size() > 0) begin
         chk(q_name.pop_front(), q_act.pop_front(), q_exp.pop_front());
      end
   end

   task automatic lit(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      q_name.push_back(nm);
      q_act.push_back(act);
      q_exp.push_back(exp);
   endtask

   task automatic cyc_start();
      exp_fault  = fault_pend;
      fault_pend = 1'b0;
      exp_cnt    = (nf > 255) ? 8'hFF : 8'(nf);
   endtask

   task automatic cyc_end();
      @(posedge clk);
      #1;
   endtask

   task automatic nop(input logic ack, input logic [31:0] a);
      MemRead_in  = 1'b0;
      MemWrite_in = 1'b0;
      MemToReg_in = a[0];
      RegWrite_in = 1'b1;
      alu_in      = a;
      RR3_in      = a[7:4];
      dm_ack      = ack;
      dm_rdata    = 32'hCAFE_F00D;
      cyc_start();
      exp_stall   = 1'b0;
      exp_req     = 1'b0;
      exp_mem_chk = 1'b1;
      exp_mem     = 32'h0;
      exp_rw      = 1'b1;
      cyc_end();
      dm_ack = 1'b0;
   endtask

   // dly: BUSY cycle on which ack arrives (1 = immediate); 0 = never
   task automatic do_op(input logic rd, input logic wr, input logic rw,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int dly, input logic [31:0] rdat,
                        output logic [31:0] busy_addr,
                        output logic [31:0] done_mem,
                        output int stalls);
      logic f, pend, to, fin;
      int   s0;
      s0 = stall_seen;
      busy_addr = 32'hFFFF_FFFF;
      done_mem  = 32'hFFFF_FFFF;
      MemRead_in  = rd;
      MemWrite_in = wr;
      MemToReg_in = rd;
      RegWrite_in = rw;
      alu_in      = a;
      wdata_in    = wd;
      RR3_in      = a[5:2];
      dm_ack      = 1'b0;
      f = (rd & wr) | ((rd | wr) &
          ((a[1:0] != 2'b00) | ({2'b0, a[31:2]} >= 32'(DW))));
      pend = rd ^ wr;
      cyc_start();
      exp_stall   = pend & ~f;
      exp_req     = 1'b0;
      exp_mem_chk = 1'b1;
      exp_mem     = 32'h0;
      exp_rw      = rw & ~(f & rd);
      cyc_end();
      if (f) begin
         nf++;
         fault_pend = 1'b1;
      end
      if (pend && !f) begin
         to  = 1'b0;
         fin = 1'b0;
         for (int k = 1; k <= TO && !fin; k++) begin
            cyc_start();
            dm_ack      = (k == dly);
            dm_rdata    = (k == dly) ? rdat : (32'hBAD0_0000 + 32'(k));
            exp_stall   = 1'b1;
            exp_req     = 1'b1;
            exp_we      = wr;
            exp_addr    = {2'b0, a[31:2]};
            exp_wdata   = wd;
            exp_mem_chk = 1'b0;
            exp_rw      = rw;
            if (k == 1) begin
               @(negedge clk);
               #1;
               busy_addr = {2'b0, dm_addr};
            end
            cyc_end();
            if (k == dly) begin
               fin = 1'b1;
            end else if (k == TO) begin
               fin = 1'b1;
               to  = 1'b1;
               nf++;
               fault_pend = 1'b1;
            end
         end
         cyc_start();
         dm_ack      = 1'b1;
         dm_rdata    = 32'h5555_AAAA;
         exp_stall   = 1'b0;
         exp_req     = 1'b0;
         exp_mem_chk = 1'b1;
         exp_mem     = (to || !rd) ? 32'h0 : rdat;
         exp_rw      = rw & ~to;
         @(negedge clk);
         #1;
         done_mem = mem_out;
         cyc_end();
         dm_ack = 1'b0;
      end
      stalls = stall_seen - s0;
   endtask

   logic [31:0] ba, dmem;
   int          st;

   initial begin
      rst = 1'b1;
      wdata_in = 32'h0;
      dm_rdata = 32'h0;
      nop(1'b0, 32'h0);
      chk_en = 1'b1;
      nop(1'b0, 32'h0);
      lit("rst_fault_cnt", {24'b0, fault_cnt}, 32'h0);
      rst = 1'b0;
      nop(1'b0, 32'h44);

      do_op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 3, 32'hDEADBEEF, ba, dmem, st);
      lit("load_addr", ba, 32'h4);
      lit("load_mem", dmem, 32'hDEADBEEF);
      lit("load_stalls", st, 32'd4);

      do_op(1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 1, 32'h0, ba, dmem, st);
      lit("store_addr", ba, 32'h8);
      lit("store_stalls", st, 32'd2);
      lit("store_mem", dmem, 32'h0);

      do_op(1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 1, 32'h0, ba, dmem, st);
      lit("misal_stalls", st, 32'd0);
      lit("misal_cnt", {24'b0, fault_cnt}, 32'd1);
      lit("misal_pulse", {31'b0, mem_fault}, 32'd1);
      nop(1'b0, 32'h8);

      do_op(1'b1, 1'b0, 1'b1, 32'h1000, 32'h0, 1, 32'h0, ba, dmem, st);
      do_op(1'b0, 1'b1, 1'b1, 32'hFFC, 32'hA5A5_0001, 2, 32'h0, ba, dmem, st);
      lit("edge_addr", ba, 32'h3FF);
      do_op(1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 1, 32'h0, ba, dmem, st);
      do_op(1'b0, 1'b1, 1'b1, 32'h22, 32'h7, 1, 32'h0, ba, dmem, st);
      nop(1'b1, 32'h30);
      nop(1'b0, 32'h31);
      do_op(1'b1, 1'b0, 1'b1, 32'hFFC, 32'h0, 1, 32'h0BAD_CAFE, ba, dmem, st);
      lit("edge_mem", dmem, 32'h0BAD_CAFE);

      do_op(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 0, 32'h0, ba, dmem, st);
      lit("to_mem", dmem, 32'h0);
      lit("to_stalls", st, 32'(TO + 1));
      nop(1'b0, 32'h0);
      do_op(1'b1, 1'b0, 1'b1, 32'h84, 32'h0, TO, 32'h1357_9BDF, ba, dmem, st);
      lit("ack_at_to_mem", dmem, 32'h1357_9BDF);
      nop(1'b0, 32'h0);

      MemRead_in = 1'b1;
      MemWrite_in = 1'b0;
      RegWrite_in = 1'b1;
      alu_in = 32'h40;
      cyc_start();
      exp_stall = 1'b1;
      exp_req = 1'b0;
      exp_mem_chk = 1'b1;
      exp_mem = 32'h0;
      exp_rw = 1'b1;
      cyc_end();
      cyc_start();
      exp_req = 1'b1;
      exp_we = 1'b0;
      exp_addr = 32'h10;
      exp_wdata = wdata_in;
      exp_mem_chk = 1'b0;
      #1;
      chk_en = 1'b0;
      MemRead_in = 1'b0;
      rst = 1'b1;
      #1;
      lit("rst_async_req", {31'b0, dm_req}, 32'h0);
      lit("rst_async_stall", {31'b0, stall_out}, 32'h0);
      lit("rst_async_cnt", {24'b0, fault_cnt}, 32'h0);
      nf = 0;
      fault_pend = 1'b0;
      cyc_end();
      rst = 1'b0;
      chk_en = 1'b1;
      nop(1'b0, 32'h0);
      nop(1'b1, 32'h0);
      nop(1'b0, 32'h0);
      nop(1'b0, 32'h0);

      for (int i = 0; i < 300; i++) begin
         do_op(1'b1, 1'b0, 1'b1, 32'h3, 32'h0, 1, 32'h0, ba, dmem, st);
      end
      nop(1'b0, 32'h0);
      lit("sat_cnt", {24'b0, fault_cnt}, 32'd255);
      nop(1'b0, 32'h0);
      nop(1'b0, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
